// File: rtl/alu_op_dispatch_if.sv
// alu_op_dispatch_if
//   Producer-side valid/ready handshake carrying one ALU operation
//   (operand A, operand B, operation code).
//
//   Handshake: an operation transfers on a rising clock edge where
//   op_valid_i and op_ready_o are both high. op_ready_o never depends on
//   op_valid_i, so the producer may look at ready before raising valid.
//
//   Signals:
//     op_valid_i  producer presents an operation
//     op_ready_o  dispatch stage can accept an operation this cycle
//     op_a_i      operand A
//     op_b_i      operand B
//     op_ctrl_i   ALU operation code
//
//   Modports:
//     master  producer side (drives valid and payload)
//     slave   dispatch side (drives ready)
interface alu_op_dispatch_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 3
);
    logic              op_valid_i;
    logic              op_ready_o;
    logic [DATA_W-1:0] op_a_i;
    logic [DATA_W-1:0] op_b_i;
    logic [CTRL_W-1:0] op_ctrl_i;

    modport master (
        output op_valid_i,
        output op_a_i,
        output op_b_i,
        output op_ctrl_i,
        input  op_ready_o
    );

    modport slave (
        input  op_valid_i,
        input  op_a_i,
        input  op_b_i,
        input  op_ctrl_i,
        output op_ready_o
    );
endinterface

// File: rtl/alu_op_dispatch.sv
// alu_op_dispatch
//   Operand dispatch stage in front of the ALU. Operations arrive over a
//   valid/ready handshake, are buffered in a DEPTH-entry FIFO and issued
//   at most one per cycle onto registered ALU-facing outputs. stall_i
//   holds issue; issued_cnt_o counts issued operations modulo 2^16.
//
//   Ports:
//     clock          sole clock, rising edge
//     rst_i          synchronous, active-high reset
//     op_if          producer handshake (slave modport)
//     stall_i        high: do not issue at this edge
//     dataA_o        registered operand A to the ALU
//     dataB_o        registered operand B to the ALU
//     ALUCtrl_o      registered operation code to the ALU
//     issue_valid_o  high in the cycle after an issue edge
//     count_o        FIFO occupancy, 0..DEPTH
//     issued_cnt_o   operations issued, wrapping at 2^16
module alu_op_dispatch #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 3,
    parameter int DEPTH  = 4
) (
    input  logic                     clock,
    input  logic                     rst_i,
    alu_op_dispatch_if.slave         op_if,
    input  logic                     stall_i,
    output logic [DATA_W-1:0]        dataA_o,
    output logic [DATA_W-1:0]        dataB_o,
    output logic [CTRL_W-1:0]        ALUCtrl_o,
    output logic                     issue_valid_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [15:0]              issued_cnt_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem_a [DEPTH];
    logic [DATA_W-1:0] mem_b [DEPTH];
    logic [CTRL_W-1:0] mem_c [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic push;
    logic pop;

    // Ready is a function of registered occupancy and reset only, so a push
    // into a full FIFO is refused even if the same edge pops an entry.
    assign op_if.op_ready_o = !rst_i && (count < FULL_CNT);
    assign push             = op_if.op_valid_i && op_if.op_ready_o;
    // Pop reads pre-edge occupancy: a freshly pushed entry cannot issue on
    // the edge that writes it.
    assign pop              = !stall_i && (count != '0);
    assign count_o          = count;

    // Storage carries no reset; reset discards contents via the pointers.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_a[wr_ptr] <= op_if.op_a_i;
            mem_b[wr_ptr] <= op_if.op_b_i;
            mem_c[wr_ptr] <= op_if.op_ctrl_i;
        end
    end

    always_ff @(posedge clock) begin
        if (rst_i) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            dataA_o       <= '0;
            dataB_o       <= '0;
            ALUCtrl_o     <= '0;
            issue_valid_o <= 1'b0;
            issued_cnt_o  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                dataA_o       <= mem_a[rd_ptr];
                dataB_o       <= mem_b[rd_ptr];
                ALUCtrl_o     <= mem_c[rd_ptr];
                rd_ptr        <= rd_ptr + 1'b1;
                issued_cnt_o  <= issued_cnt_o + 16'd1;
                issue_valid_o <= 1'b1;
            end else begin
                issue_valid_o <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_op_dispatch.sv
module tb_alu_op_dispatch;
    localparam int DATA_W = 32;
    localparam int CTRL_W = 3;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int OP_W   = CTRL_W + 2 * DATA_W;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic              rst_i;
    logic              stall_i;
    logic [DATA_W-1:0] dataA_o;
    logic [DATA_W-1:0] dataB_o;
    logic [CTRL_W-1:0] ALUCtrl_o;
    logic              issue_valid_o;
    logic [CNT_W-1:0]  count_o;
    logic [15:0]       issued_cnt_o;

    alu_op_dispatch_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) op_if ();

    alu_op_dispatch #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .DEPTH(DEPTH)) dut (
        .clock         (clock),
        .rst_i         (rst_i),
        .op_if         (op_if),
        .stall_i       (stall_i),
        .dataA_o       (dataA_o),
        .dataB_o       (dataB_o),
        .ALUCtrl_o     (ALUCtrl_o),
        .issue_valid_o (issue_valid_o),
        .count_o       (count_o),
        .issued_cnt_o  (issued_cnt_o)
    );

    // ---------------- scoreboard / reference model ----------------
    // Pending operations in arrival order, packed {ctrl, b, a}.
    logic [OP_W-1:0]   exp_q[$];
    logic [DATA_W-1:0] exp_a;
    logic [DATA_W-1:0] exp_b;
    logic [CTRL_W-1:0] exp_c;
    logic              exp_iv;
    logic [15:0]       exp_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge: applies inputs, checks ready, lets one rising
    // edge pass, advances the model, then checks outputs at the falling edge.
    task automatic drive_cycle(input logic rst, input logic valid,
                               input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                               input logic [CTRL_W-1:0] c, input logic stall);
        logic            exp_ready;
        logic [OP_W-1:0] head;
        rst_i            = rst;
        op_if.op_valid_i = valid;
        op_if.op_a_i     = a;
        op_if.op_b_i     = b;
        op_if.op_ctrl_i  = c;
        stall_i          = stall;
        #1;
        exp_ready = !rst && (exp_q.size() < DEPTH);
        check("op_ready", 64'(op_if.op_ready_o), 64'(exp_ready));
        @(posedge clock);
        if (rst) begin
            exp_q.delete();
            exp_a   = '0;
            exp_b   = '0;
            exp_c   = '0;
            exp_iv  = 1'b0;
            exp_cnt = '0;
        end else begin
            if (!stall && exp_q.size() != 0) begin
                head    = exp_q.pop_front();
                exp_a   = head[DATA_W-1:0];
                exp_b   = head[2*DATA_W-1:DATA_W];
                exp_c   = head[OP_W-1:2*DATA_W];
                exp_iv  = 1'b1;
                exp_cnt = exp_cnt + 16'd1;
            end else begin
                exp_iv = 1'b0;
            end
            if (valid && exp_ready) exp_q.push_back({c, b, a});
        end
        @(negedge clock);
        check("dataA", 64'(dataA_o), 64'(exp_a));
        check("dataB", 64'(dataB_o), 64'(exp_b));
        check("ALUCtrl", 64'(ALUCtrl_o), 64'(exp_c));
        check("issue_valid", 64'(issue_valid_o), 64'(exp_iv));
        check("count", 64'(count_o), 64'(exp_q.size()));
        check("issued_cnt", 64'(issued_cnt_o), 64'(exp_cnt));
    endtask

    task automatic idle(input logic stall);
        drive_cycle(1'b0, 1'b0, $urandom, $urandom, CTRL_W'($urandom), stall);
    endtask

    task automatic do_reset();
        drive_cycle(1'b1, 1'b1, $urandom, $urandom, CTRL_W'($urandom), 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int guard;
        exp_a = '0; exp_b = '0; exp_c = '0; exp_iv = 1'b0; exp_cnt = '0;

        do_reset();
        do_reset();

        // Single op: issues one edge after the push.
        drive_cycle(1'b0, 1'b1, 32'h5, 32'h3, 3'b010, 1'b0);
        check("single_no_bypass", 64'(issue_valid_o), 64'd0);
        idle(1'b0);
        check("single_dataA", 64'(dataA_o), 64'h5);
        check("single_dataB", 64'(dataB_o), 64'h3);
        check("single_ctrl", 64'(ALUCtrl_o), 64'h2);
        check("single_issued", 64'(issued_cnt_o), 64'h1);
        idle(1'b0);
        check("single_iv_drops", 64'(issue_valid_o), 64'd0);

        // Fill under stall, 5th push refused, then drain in order.
        do_reset();
        for (int i = 1; i <= 4; i++) drive_cycle(1'b0, 1'b1, 32'(i), $urandom, CTRL_W'(i), 1'b1);
        check("fill_count", 64'(count_o), 64'd4);
        check("fill_ready_low", 64'(op_if.op_ready_o), 64'd0);
        drive_cycle(1'b0, 1'b1, 32'h5, 32'h5, 3'd5, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            idle(1'b0);
            check("drain_order", 64'(dataA_o), 64'(i));
        end
        idle(1'b0);

        // Streaming across the pointer wrap.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive_cycle(1'b0, 1'b1, 32'(32'h10 + i), $urandom, CTRL_W'(i % 8), 1'b0);
            check("stream_count_le1", 64'(count_o <= 1), 64'd1);
        end
        idle(1'b0);
        check("stream_last", 64'(dataA_o), 64'h19);
        check("stream_issued", 64'(issued_cnt_o), 64'd10);

        // Simultaneous push and pop at occupancy 2.
        do_reset();
        drive_cycle(1'b0, 1'b1, 32'hA1, 32'hB1, 3'd6, 1'b1);
        drive_cycle(1'b0, 1'b1, 32'hA2, 32'hB2, 3'd7, 1'b1);
        drive_cycle(1'b0, 1'b1, 32'hA3, 32'hB3, 3'd1, 1'b0);
        check("simul_count", 64'(count_o), 64'd2);
        check("simul_oldest", 64'(dataA_o), 64'hA1);
        idle(1'b0); idle(1'b0); idle(1'b0);

        // Reset mid-operation discards queued ops.
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b1, $urandom, $urandom, CTRL_W'($urandom), 1'b1);
        idle(1'b0);
        do_reset();
        check("rst_mid_count", 64'(count_o), 64'd0);
        check("rst_mid_dataA", 64'(dataA_o), 64'd0);
        for (int i = 0; i < 3; i++) idle(1'b0);

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 600; i++) begin
            drive_cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                        $urandom, $urandom, CTRL_W'($urandom), ($urandom_range(0, 2) == 0));
        end

        // Issued counter wrap.
        do_reset();
        guard = 0;
        while (exp_cnt != 16'hFFFF && guard < 70000) begin
            drive_cycle(1'b0, 1'b1, $urandom, $urandom, CTRL_W'($urandom), 1'b0);
            guard++;
        end
        check("wrap_budget", 64'(guard < 70000), 64'd1);
        check("wrap_ffff", 64'(issued_cnt_o), 64'hFFFF);
        idle(1'b0);
        check("wrap_zero", 64'(issued_cnt_o), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
